// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, runs a one-outstanding valid/ready fetch to imem,
// buffers a returned instruction while decode is frozen, and drives the IF/ID register.
module if_fetch_stage #(
   parameter int unsigned     XLEN      = 32,
   parameter logic [XLEN-1:0] RESET_PC  = '0,
   parameter logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            PC_Write,
   input  logic            IF_ID_Write,
   input  logic            Flush,
   input  logic            Redirect_Valid,
   input  logic [XLEN-1:0] Redirect_PC,
   output logic            Imem_Req_Valid,
   input  logic            Imem_Req_Ready,
   output logic [XLEN-1:0] Imem_Req_Addr,
   input  logic            Imem_Resp_Valid,
   input  logic [XLEN-1:0] Imem_Resp_Data,
   output logic [XLEN-1:0] IF_ID_PC,
   output logic [XLEN-1:0] IF_ID_Instr,
   output logic            IF_ID_Valid
);

   typedef enum logic [1:0] {StReq, StWait, StFull} state_e;

   state_e          state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] buf_q, buf_d;
   logic            drop_q, drop_d;
   logic [XLEN-1:0] ifid_pc_q, ifid_instr_q;
   logic            ifid_valid_q;

   logic            advance;
   logic            deliver;
   logic [XLEN-1:0] deliver_instr;
   logic [XLEN-1:0] redirect_target;
   logic            unused_redirect_lsbs;

   assign advance              = IF_ID_Write & PC_Write & ~Flush;
   assign redirect_target      = {Redirect_PC[XLEN-1:2], 2'b00};
   assign unused_redirect_lsbs = ^Redirect_PC[1:0];

   // A redirect in the request state suppresses the request so the stale address never issues.
   assign Imem_Req_Valid = (state_q == StReq) & ~rst & ~Redirect_Valid;
   assign Imem_Req_Addr  = pc_q;

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      buf_d         = buf_q;
      drop_d        = drop_q;
      deliver       = 1'b0;
      deliver_instr = Imem_Resp_Data;
      unique case (state_q)
         StReq: begin
            if (Redirect_Valid) begin
               pc_d = redirect_target;
            end else if (Imem_Req_Ready) begin
               state_d = StWait;
            end
         end
         StWait: begin
            if (Redirect_Valid) begin
               pc_d = redirect_target;
               if (Imem_Resp_Valid) begin
                  state_d = StReq;
                  drop_d  = 1'b0;
               end else begin
                  drop_d = 1'b1;
               end
            end else if (Imem_Resp_Valid) begin
               if (drop_q) begin
                  drop_d  = 1'b0;
                  state_d = StReq;
               end else if (advance) begin
                  deliver = 1'b1;
                  pc_d    = pc_q + XLEN'(4);
                  state_d = StReq;
               end else begin
                  buf_d   = Imem_Resp_Data;
                  state_d = StFull;
               end
            end
         end
         StFull: begin
            if (Redirect_Valid) begin
               pc_d    = redirect_target;
               state_d = StReq;
            end else if (advance) begin
               deliver       = 1'b1;
               deliver_instr = buf_q;
               pc_d          = pc_q + XLEN'(4);
               state_d       = StReq;
            end
         end
         default: state_d = StReq;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StReq;
         pc_q         <= RESET_PC;
         buf_q        <= NOP_INSTR;
         drop_q       <= 1'b0;
         ifid_pc_q    <= '0;
         ifid_instr_q <= NOP_INSTR;
         ifid_valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         buf_q   <= buf_d;
         drop_q  <= drop_d;
         // Flush squashes but keeps the PC; IF_ID_Write=0 simply holds everything.
         if (Flush) begin
            ifid_valid_q <= 1'b0;
            ifid_instr_q <= NOP_INSTR;
         end else if (IF_ID_Write) begin
            if (deliver) begin
               ifid_pc_q    <= pc_q;
               ifid_instr_q <= deliver_instr;
               ifid_valid_q <= 1'b1;
            end else begin
               ifid_valid_q <= 1'b0;
               ifid_instr_q <= NOP_INSTR;
            end
         end
      end
   end

   assign IF_ID_PC    = ifid_pc_q;
   assign IF_ID_Instr = ifid_instr_q;
   assign IF_ID_Valid = ifid_valid_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: a memory responder returning Instr=addr and a queue of
// expected IF/ID PCs popped whenever the IF/ID register loads a valid instruction.
module tb_if_fetch_stage;

   localparam logic [31:0] Nop = 32'h0000_0013;

   logic        clk;
   logic        rst;
   logic        PC_Write, IF_ID_Write, Flush, Redirect_Valid;
   logic [31:0] Redirect_PC;
   logic        Imem_Req_Valid, Imem_Req_Ready;
   logic [31:0] Imem_Req_Addr;
   logic        Imem_Resp_Valid;
   logic [31:0] Imem_Resp_Data;
   logic [31:0] IF_ID_PC, IF_ID_Instr;
   logic        IF_ID_Valid;

   int unsigned total = 0;
   int unsigned bad   = 0;

   logic [31:0] q[$];
   int          delay;
   int          pend_cnt;
   logic [31:0] pend_addr;
   logic        acc_s, ld_s, resp_s;
   logic [31:0] acc_addr_s;

   if_fetch_stage #(
      .XLEN     (32),
      .RESET_PC (32'h0000_0000),
      .NOP_INSTR(32'h0000_0013)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .PC_Write       (PC_Write),
      .IF_ID_Write    (IF_ID_Write),
      .Flush          (Flush),
      .Redirect_Valid (Redirect_Valid),
      .Redirect_PC    (Redirect_PC),
      .Imem_Req_Valid (Imem_Req_Valid),
      .Imem_Req_Ready (Imem_Req_Ready),
      .Imem_Req_Addr  (Imem_Req_Addr),
      .Imem_Resp_Valid(Imem_Resp_Valid),
      .Imem_Resp_Data (Imem_Resp_Data),
      .IF_ID_PC       (IF_ID_PC),
      .IF_ID_Instr    (IF_ID_Instr),
      .IF_ID_Valid    (IF_ID_Valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   // Drive the response for this cycle and sample what the DUT will see at the edge.
   task automatic cyc_begin();
      if (pend_cnt == 1) begin
         Imem_Resp_Valid = 1'b1;
         Imem_Resp_Data  = pend_addr;
      end else begin
         Imem_Resp_Valid = 1'b0;
         Imem_Resp_Data  = 32'hDEAD_BEEF;
      end
      #2;
      resp_s     = Imem_Resp_Valid;
      acc_s      = Imem_Req_Valid & Imem_Req_Ready;
      acc_addr_s = Imem_Req_Addr;
      ld_s       = ~rst & IF_ID_Write & ~Flush;
   endtask

   task automatic cyc_end();
      logic [31:0] e;
      @(posedge clk);
      #1;
      if (resp_s) pend_cnt = 0;
      else if (pend_cnt > 1) pend_cnt--;
      if (acc_s) begin
         pend_cnt  = delay;
         pend_addr = acc_addr_s;
      end
      if (ld_s && IF_ID_Valid === 1'b1) begin
         total++;
         assert (q.size() != 0)
         else begin
            bad++;
            $error("FAIL sb_unexpected: got pc %h want no delivery", IF_ID_PC);
         end
         if (q.size() != 0) begin
            e = q.pop_front();
            chk("sb_pc", IF_ID_PC, e);
            chk("sb_instr", IF_ID_Instr, e);
         end
      end
   endtask

   task automatic tick();
      cyc_begin();
      cyc_end();
   endtask

   initial begin
      rst = 1'b1; PC_Write = 1'b1; IF_ID_Write = 1'b1; Flush = 1'b0;
      Redirect_Valid = 1'b0; Redirect_PC = '0; Imem_Req_Ready = 1'b1;
      Imem_Resp_Valid = 1'b0; Imem_Resp_Data = '0;
      delay = 1; pend_cnt = 0; pend_addr = '0;

      cyc_begin();
      chk("rst_req_valid", {31'd0, Imem_Req_Valid}, 32'd0);
      cyc_end();
      tick();
      chk("rst_valid", {31'd0, IF_ID_Valid}, 32'd0);
      chk("rst_instr", IF_ID_Instr, Nop);
      chk("rst_pc", IF_ID_PC, 32'd0);
      rst = 1'b0;

      // Free run: valid on every second edge, starting at the second edge.
      q.push_back(32'h0); q.push_back(32'h4);
      for (int k = 1; k <= 4; k++) begin
         cyc_begin();
         if (k == 1) begin
            chk("first_req_valid", {31'd0, Imem_Req_Valid}, 32'd1);
            chk("first_req_addr", Imem_Req_Addr, 32'h0);
         end
         cyc_end();
         chk("free_valid", {31'd0, IF_ID_Valid}, ((k % 2) == 0) ? 32'd1 : 32'd0);
      end

      // Load-use stall when 0x8 returns.
      q.push_back(32'h8);
      cyc_begin(); chk("req_8", Imem_Req_Addr, 32'h8); cyc_end();
      PC_Write = 1'b0; IF_ID_Write = 1'b0;
      for (int k = 0; k < 3; k++) begin
         cyc_begin();
         chk("stall_no_req", {31'd0, Imem_Req_Valid}, 32'd0);
         cyc_end();
         chk("stall_hold_pc", IF_ID_PC, 32'h4);
         chk("stall_hold_valid", {31'd0, IF_ID_Valid}, 32'd0);
      end
      PC_Write = 1'b1; IF_ID_Write = 1'b1;
      tick();
      chk("stall_release_valid", {31'd0, IF_ID_Valid}, 32'd1);
      q.push_back(32'hC);
      cyc_begin(); chk("req_c", Imem_Req_Addr, 32'hC); cyc_end();
      tick();

      // Redirect while waiting on a slow response for 0x10.
      delay = 3;
      cyc_begin(); chk("req_10", Imem_Req_Addr, 32'h10); cyc_end();
      Redirect_Valid = 1'b1; Redirect_PC = 32'h103;
      tick();
      Redirect_Valid = 1'b0;
      tick();
      tick();
      chk("drop_valid", {31'd0, IF_ID_Valid}, 32'd0);
      delay = 1;
      q.push_back(32'h100);
      cyc_begin();
      chk("redir_req_valid", {31'd0, Imem_Req_Valid}, 32'd1);
      chk("redir_req_addr", Imem_Req_Addr, 32'h100);
      cyc_end();
      tick();
      chk("redir_deliver_valid", {31'd0, IF_ID_Valid}, 32'd1);

      // Redirect + Flush coincident with the response for 0x104.
      cyc_begin(); chk("req_104", Imem_Req_Addr, 32'h104); cyc_end();
      Redirect_Valid = 1'b1; Redirect_PC = 32'h200; Flush = 1'b1;
      tick();
      Redirect_Valid = 1'b0; Flush = 1'b0;
      chk("rf_valid", {31'd0, IF_ID_Valid}, 32'd0);
      chk("rf_instr", IF_ID_Instr, Nop);
      q.push_back(32'h200);
      cyc_begin(); chk("rf_req_addr", Imem_Req_Addr, 32'h200); cyc_end();
      tick();

      // Flush alone while 0x20 returns: it must come from the buffer.
      Redirect_Valid = 1'b1; Redirect_PC = 32'h20;
      cyc_begin();
      chk("redir_suppress_req", {31'd0, Imem_Req_Valid}, 32'd0);
      cyc_end();
      Redirect_Valid = 1'b0;
      cyc_begin(); chk("req_20", Imem_Req_Addr, 32'h20); cyc_end();
      Flush = 1'b1;
      tick();
      Flush = 1'b0;
      chk("flush_valid", {31'd0, IF_ID_Valid}, 32'd0);
      q.push_back(32'h20);
      cyc_begin();
      chk("buf_no_refetch", {31'd0, Imem_Req_Valid}, 32'd0);
      cyc_end();
      chk("buf_deliver_valid", {31'd0, IF_ID_Valid}, 32'd1);

      // Backpressure then reset mid-WAIT with a stale response afterwards.
      Imem_Req_Ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         cyc_begin();
         chk("bp_req_valid", {31'd0, Imem_Req_Valid}, 32'd1);
         chk("bp_req_addr", Imem_Req_Addr, 32'h24);
         cyc_end();
      end
      Imem_Req_Ready = 1'b1; delay = 3;
      tick();
      rst = 1'b1;
      cyc_begin();
      chk("rst_mid_req_valid", {31'd0, Imem_Req_Valid}, 32'd0);
      cyc_end();
      rst = 1'b0; Imem_Req_Ready = 1'b0;
      chk("rst2_valid", {31'd0, IF_ID_Valid}, 32'd0);
      chk("rst2_instr", IF_ID_Instr, Nop);
      chk("rst2_pc", IF_ID_PC, 32'h0);
      tick();
      cyc_begin();
      chk("stale_req_addr", Imem_Req_Addr, 32'h0);
      chk("stale_req_valid", {31'd0, Imem_Req_Valid}, 32'd1);
      cyc_end();
      chk("stale_ignored", {31'd0, IF_ID_Valid}, 32'd0);
      Imem_Req_Ready = 1'b1; delay = 1;
      q.push_back(32'h0);
      cyc_begin(); chk("post_rst_addr", Imem_Req_Addr, 32'h0); cyc_end();
      tick();
      chk("post_rst_valid", {31'd0, IF_ID_Valid}, 32'd1);

      // PC wrap, with unaligned redirect bits masked.
      Redirect_Valid = 1'b1; Redirect_PC = 32'hFFFF_FFFE;
      tick();
      Redirect_Valid = 1'b0;
      q.push_back(32'hFFFF_FFFC);
      cyc_begin(); chk("wrap_req_top", Imem_Req_Addr, 32'hFFFF_FFFC); cyc_end();
      tick();
      q.push_back(32'h0);
      cyc_begin(); chk("wrap_req_zero", Imem_Req_Addr, 32'h0); cyc_end();
      tick();

      chk("sb_empty", q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
